// File: rtl/debounce_pkg.sv
// debounce_pkg: shared hold-FSM state type and counter width helper
package debounce_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} hold_state_t;
  function automatic int cnt_width(input int mx);
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction
endpackage

// File: rtl/debounce_if.sv
// debounce_if: raw inputs and debounced outputs of a debounce_array
interface debounce_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0] dirty_in;
  logic [NUM_CH-1:0] clean_out;
  logic [NUM_CH-1:0] press_out;
  logic [NUM_CH-1:0] release_out;
  logic [NUM_CH-1:0] hold_out;
  modport master (output dirty_in, input clean_out, press_out, release_out, hold_out);
  modport slave (input dirty_in, output clean_out, press_out, release_out, hold_out);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, debounce counter, edge strobes and hold/repeat FSM for one input
module debounce_channel import debounce_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_MAX = HW'(REPEAT_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hc_q, hc_d;
  logic clean_q, clean_d, press_q, release_q, hold_q, hold_d;
  logic s, flip, rise, fall;
  hold_state_t st_q, st_d;
  assign s = sync_q[SYNC_STAGES-1];
  assign flip = (s != clean_q) && (cnt_q == DEB_LAST);
  assign rise = flip && s;
  assign fall = flip && !s;
  assign clean_d = flip ? s : clean_q;
  assign cnt_d = (s == clean_q || flip) ? '0 : cnt_q + 1'b1;
  // hold timing starts on the edge that raises clean, so hc is 1 in the press_out cycle
  always_comb begin
    st_d = st_q;
    hc_d = hc_q;
    hold_d = 1'b0;
    if (fall || HOLD_CYCLES == 0) begin
      st_d = IDLE;
      hc_d = '0;
    end else begin
      case (st_q)
        IDLE: if (rise) begin
          st_d = WAIT_HOLD;
          hc_d = HW'(1);
        end
        WAIT_HOLD: if (hc_q == HOLD_MAX) begin
          hold_d = 1'b1;
          st_d = REPEAT;
          hc_d = (REPEAT_CYCLES == 0) ? '0 : HW'(1);
        end else hc_d = hc_q + 1'b1;
        REPEAT: if (REPEAT_CYCLES != 0) begin
          hold_d = (hc_q == REP_MAX);
          hc_d = (hc_q == REP_MAX) ? HW'(1) : hc_q + 1'b1;
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sync_q <= '0;
      cnt_q <= '0;
      clean_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
      hold_q <= 1'b0;
      st_q <= IDLE;
      hc_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q <= cnt_d;
      clean_q <= clean_d;
      press_q <= rise;
      release_q <= fall;
      hold_q <= hold_d;
      st_q <= st_d;
      hc_q <= hc_d;
    end
  assign clean_o = clean_q;
  assign press_o = press_q;
  assign release_o = release_q;
  assign hold_o = hold_q;
endmodule

// File: rtl/debounce_array.sv
// debounce_array: NUM_CH independent debounce channels with per-channel input polarity
module debounce_array #(
  parameter int NUM_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW = '0
) (
  input logic clk_in,
  input logic rst_n_in,
  debounce_if.slave bus
);
  logic [NUM_CH-1:0] clean, press, rel, hold;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .raw_i(bus.dirty_in[i] ^ ACTIVE_LOW[i]),
      .clean_o(clean[i]),
      .press_o(press[i]),
      .release_o(rel[i]),
      .hold_o(hold[i])
    );
  end
  assign bus.clean_out = clean;
  assign bus.press_out = press;
  assign bus.release_out = rel;
  assign bus.hold_out = hold;
endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: directed stimulus checked every cycle against a sample-window reference model
module tb_debounce_array;
  localparam int NCH = 4, SYNC = 2, DEB = 4, HOLD = 20, REP = 8;
  localparam logic [3:0] AL = 4'b1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0, errs = 0;
  debounce_if #(.NUM_CH(NCH)) bus ();
  debounce_array #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(AL)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // reference: clean flips once the last DEB synchronised samples all disagree with it
  bit hist [NCH][4096];
  bit [3:0] m_cl, m_pr, m_rl, m_hd;
  int since [NCH];
  int n = 0;
  function automatic bit s_at(input int c, input int k);
    return (k - SYNC >= 1) ? hist[c][k-SYNC] : 1'b0;
  endfunction
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0;
      {m_cl, m_pr, m_rl, m_hd} = '0;
      for (int c = 0; c < NCH; c++) since[c] = 0;
    end else begin
      n++;
      for (int c = 0; c < NCH; c++) begin
        bit flip, was;
        hist[c][n] = bus.dirty_in[c] ^ AL[c];
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) if (s_at(c, n - j) == m_cl[c]) flip = 1'b0;
        was = m_cl[c];
        m_pr[c] = flip && !was;
        m_rl[c] = flip && was;
        if (flip) m_cl[c] = !was;
        if (m_pr[c]) since[c] = 0;
        else if (m_cl[c]) since[c]++;
        m_hd[c] = m_cl[c] && !m_pr[c] &&
                  (since[c] == HOLD || (since[c] > HOLD && ((since[c] - HOLD) % REP) == 0));
      end
    end
  end
  initial forever begin
    @(negedge clk);
    vecs++;
    if ({bus.clean_out, bus.press_out, bus.release_out, bus.hold_out} !== {m_cl, m_pr, m_rl, m_hd}) begin
      errs++;
      $display("FAIL model t=%0t got c/p/r/h=%b/%b/%b/%b want %b/%b/%b/%b", $time,
               bus.clean_out, bus.press_out, bus.release_out, bus.hold_out, m_cl, m_pr, m_rl, m_hd);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic wn(input int k);
    repeat (k) @(negedge clk);
  endtask
  int bp [7] = '{1, 1, 0, 1, 1, 1, 1};
  int got [$];
  initial begin
    bus.dirty_in = 4'b1111;
    wn(3);
    chk("rst_clean", bus.clean_out, 0);
    chk("rst_press", bus.press_out, 0);
    chk("rst_hold", bus.hold_out, 0);
    rst_n = 1'b1;
    wn(5);
    chk("por_clean_e5", bus.clean_out, 0);
    wn(1);
    chk("por_clean_e6", bus.clean_out, 4'b0111);
    chk("por_press_e6", bus.press_out, 4'b0111);
    wn(1);
    chk("por_press_e7", bus.press_out, 0);
    bus.dirty_in = 4'b1000;
    wn(6);
    chk("rel_all", bus.release_out, 4'b0111);
    wn(4);
    bus.dirty_in[0] = 1'b1;
    wn(3);
    bus.dirty_in[0] = 1'b0;
    wn(10);
    chk("glitch_clean", bus.clean_out, 0);
    bus.dirty_in[0] = 1'b1;
    wn(5);
    chk("ch0_clean_e5", bus.clean_out, 0);
    wn(1);
    chk("ch0_press_e6", bus.press_out, 4'b0001);
    wn(14);
    bus.dirty_in[0] = 1'b0;
    wn(6);
    chk("ch0_rel_at_hold", bus.release_out, 4'b0001);
    chk("ch0_hold_supp", bus.hold_out, 0);
    wn(20);
    for (int i = 0; i < 7; i++) begin
      bus.dirty_in[1] = bp[i][0];
      wn(1);
    end
    wn(1);
    chk("bounce_clean_e5", bus.clean_out, 0);
    wn(1);
    chk("bounce_press_e6", bus.press_out, 4'b0010);
    bus.dirty_in[1] = 1'b0;
    wn(12);
    bus.dirty_in[2] = 1'b1;
    wn(6);
    chk("ch2_press", bus.press_out, 4'b0100);
    for (int k = 1; k <= 56; k++) begin
      wn(1);
      if (bus.hold_out[2]) got.push_back(k);
    end
    chk("hold_count", got.size(), 5);
    for (int i = 0; i < 5; i++) if (i < got.size()) chk("hold_offset", got[i], 20 + 8 * i);
    bus.dirty_in[2] = 1'b0;
    wn(6);
    chk("ch2_release", bus.release_out, 4'b0100);
    wn(20);
    bus.dirty_in[2] = 1'b1;
    wn(32);
    chk("ch2_pre_rst", bus.clean_out, 4'b0100);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {bus.clean_out, bus.press_out, bus.release_out, bus.hold_out}, 0);
    wn(2);
    rst_n = 1'b1;
    wn(5);
    chk("rerst_clean_e5", bus.clean_out, 0);
    wn(1);
    chk("rerst_press_e6", bus.press_out, 4'b0100);
    wn(19);
    chk("rerst_hold_19", bus.hold_out, 0);
    wn(1);
    chk("rerst_hold_20", bus.hold_out, 4'b0100);
    wn(3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
